// File: rtl/oh_pads_pkg.sv
// Shared definitions for the padring power sequencer: FSM state encoding,
// timeout reload constant and small index helpers.
package oh_pads_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UP_DLY = 3'd1,
      ST_UP_ACK = 3'd2,
      ST_ON     = 3'd3,
      ST_DN_DLY = 3'd4,
      ST_ERR    = 3'd5
   } pads_state_t;

   localparam int MAX_SEGS = 16;

   // All-ones value of a TW-bit timeout counter.
   function automatic logic [31:0] tmo_reload(input int tw);
      return (tw >= 32) ? 32'hffff_ffff : ((32'd1 << tw) - 32'd1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [3:0] top_bit(input logic [MAX_SEGS-1:0] v);
      logic [3:0] r;
      r = '0;
      for (int k = 0; k < MAX_SEGS; k++) begin
         if (v[k]) r = 4'(k);
      end
      return r;
   endfunction

endpackage

// File: rtl/oh_pads_timer.sv
// Loadable down-counter that saturates at zero and raises a terminal flag.
module oh_pads_timer #(
   parameter int W     = 8,
   // EARLY also flags count==1, so the owner can act on the edge where the
   // count reaches zero rather than one cycle after it.
   parameter bit EARLY = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0) || (EARLY && (count == W'(1)));

endmodule

// File: rtl/oh_pads_seq.sv
// Padring power sequencer: releases pad segments one at a time on the way up,
// waits for each supply-good, and retires them in reverse order on the way down.
//
//   state  | meaning
//   IDLE   | all segments off, waiting for start
//   UP_DLY | inter-segment delay before enabling segment idx
//   UP_ACK | segment idx enabled, waiting for its supply-good (with timeout)
//   ON     | all segments enabled and acknowledged
//   DN_DLY | delay before disabling segment idx, then idx-1 ... down to 0
//   ERR    | acknowledge timeout; everything off until reset
module oh_pads_seq
   import oh_pads_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int TW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic [DW-1:0] delay,
   input  logic [N-1:0]  seg_ack,
   output logic [N-1:0]  seg_en,
   output logic          busy,
   output logic          done,
   output logic          error
);

   localparam int            IW       = idx_width(N);
   localparam logic [TW-1:0] TMO_LOAD = TW'(tmo_reload(TW));
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   pads_state_t   state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [N-1:0]  en_n;
   logic [DW-1:0] dly_lat;
   logic [DW-1:0] dly_val;
   logic          dly_load, dly_dec, dly_zero;
   logic          tmo_load, tmo_dec, tmo_zero;
   logic          any_en;
   logic [IW-1:0] abort_idx;

   assign any_en    = |seg_en;
   assign abort_idx = IW'(top_bit(MAX_SEGS'(seg_en)));
   // The live delay input only matters on the IDLE exit; afterwards the copy rules.
   assign dly_val   = (state == ST_IDLE) ? delay : dly_lat;

   oh_pads_timer #(.W(DW), .EARLY(1'b0)) u_dly (
      .clk      (clk),
      .reset    (reset),
      .load     (dly_load),
      .load_val (dly_val),
      .dec      (dly_dec),
      .zero     (dly_zero)
   );

   oh_pads_timer #(.W(TW), .EARLY(1'b1)) u_tmo (
      .clk      (clk),
      .reset    (reset),
      .load     (tmo_load),
      .load_val (TMO_LOAD),
      .dec      (tmo_dec),
      .zero     (tmo_zero)
   );

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      en_n     = seg_en;
      dly_load = 1'b0;
      dly_dec  = 1'b0;
      tmo_load = 1'b0;
      tmo_dec  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               state_n  = ST_UP_DLY;
               idx_n    = '0;
               dly_load = 1'b1;
            end
         end
         ST_UP_DLY: begin
            if (stop) begin
               if (any_en) begin
                  state_n  = ST_DN_DLY;
                  idx_n    = abort_idx;
                  dly_load = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end else if (dly_zero) begin
               en_n[idx] = 1'b1;
               state_n   = ST_UP_ACK;
               tmo_load  = 1'b1;
            end else begin
               dly_dec = 1'b1;
            end
         end
         ST_UP_ACK: begin
            if (stop) begin
               // The segment under test is already enabled, so abort_idx is valid.
               state_n  = ST_DN_DLY;
               idx_n    = abort_idx;
               dly_load = 1'b1;
            end else if (seg_ack[idx]) begin
               if (idx == IDX_LAST) begin
                  state_n = ST_ON;
               end else begin
                  idx_n    = idx + IW'(1);
                  state_n  = ST_UP_DLY;
                  dly_load = 1'b1;
               end
            end else if (tmo_zero) begin
               state_n = ST_ERR;
               en_n    = '0;
            end else begin
               tmo_dec = 1'b1;
            end
         end
         ST_ON: begin
            if (stop) begin
               state_n  = ST_DN_DLY;
               idx_n    = IDX_LAST;
               dly_load = 1'b1;
            end
         end
         ST_DN_DLY: begin
            if (dly_zero) begin
               en_n[idx] = 1'b0;
               if (idx == '0) begin
                  state_n = ST_IDLE;
               end else begin
                  idx_n    = idx - IW'(1);
                  dly_load = 1'b1;
               end
            end else begin
               dly_dec = 1'b1;
            end
         end
         ST_ERR: begin
            state_n = ST_ERR;
         end
         default: begin
            state_n = ST_IDLE;
            en_n    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         idx     <= '0;
         seg_en  <= '0;
         dly_lat <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         seg_en <= en_n;
         if ((state == ST_IDLE) && (state_n == ST_UP_DLY)) begin
            dly_lat <= delay;
         end
         busy  <= (state_n == ST_UP_DLY) || (state_n == ST_UP_ACK) || (state_n == ST_DN_DLY);
         done  <= (state_n == ST_ON);
         error <= (state_n == ST_ERR);
      end
   end

endmodule

// File: tb/tb_oh_pads_seq.sv
// Self-checking bench for oh_pads_seq: directed scenarios with literal timing,
// then randomized traffic checked every cycle against a behavioural model.
module tb_oh_pads_seq;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int TW      = 4;
   localparam int TMO_CYC = (1 << TW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [DW-1:0] delay = '0;
   logic [N-1:0]  seg_ack = '0;
   logic [N-1:0]  seg_en;
   logic          busy, done, error;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   oh_pads_seq #(.N(N), .DW(DW), .TW(TW)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .stop    (stop),
      .delay   (delay),
      .seg_ack (seg_ack),
      .seg_en  (seg_en),
      .busy    (busy),
      .done    (done),
      .error   (error)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase 0 at rest, 1 powering up, 2 powering down, 3 fault.
   int           m_phase = 0;
   logic [N-1:0] m_en = '0;
   int           m_seg = 0;
   int           m_left = 0;
   int           m_ack_age = 0;
   int           m_dly = 0;
   bit           m_wait_ack = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0; m_en = '0; m_seg = 0; m_left = 0;
         m_ack_age = 0; m_dly = 0; m_wait_ack = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               if (m_en == '0) begin
                  if (start && !stop) begin
                     m_phase = 1; m_seg = 0; m_dly = int'(delay);
                     m_left = m_dly + 1; m_wait_ack = 1'b0;
                  end
               end else if (stop) begin
                  m_phase = 2; m_seg = N - 1; m_left = m_dly + 1;
               end
            end
            1: begin
               if (stop) begin
                  if (m_en == '0) begin
                     m_phase = 0;
                  end else begin
                     m_phase = 2;
                     for (int k = 0; k < N; k++) if (m_en[k]) m_seg = k;
                     m_left = m_dly + 1;
                  end
               end else if (!m_wait_ack) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_en[m_seg] = 1'b1; m_wait_ack = 1'b1; m_ack_age = 0;
                  end
               end else begin
                  m_ack_age++;
                  if (seg_ack[m_seg]) begin
                     if (m_seg == N - 1) m_phase = 0;
                     else begin
                        m_seg++; m_wait_ack = 1'b0; m_left = m_dly + 1;
                     end
                  end else if (m_ack_age == TMO_CYC) begin
                     m_phase = 3; m_en = '0;
                  end
               end
            end
            2: begin
               m_left--;
               if (m_left == 0) begin
                  m_en[m_seg] = 1'b0;
                  if (m_seg == 0) m_phase = 0;
                  else begin
                     m_seg--; m_left = m_dly + 1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model seg_en", 32'(seg_en), 32'(m_en));
         check("model busy", 32'(busy), 32'((m_phase == 1) || (m_phase == 2)));
         check("model done", 32'(done), 32'((m_phase == 0) && (m_en == '1)));
         check("model error", 32'(error), 32'(m_phase == 3));
      end
   end

   // Padring responder: supply-good follows enable two cycles later, or random.
   logic [N-1:0] h1 = '0, h2 = '0, hold_low = '0;
   bit           ack_rand = 1'b0;

   task automatic tick();
      @(negedge clk);
      h2 = h1;
      h1 = seg_en;
      if (ack_rand) seg_ack = N'($urandom);
      else          seg_ack = h2 & ~hold_low;
   endtask

   task automatic apply_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      h1 = '0; h2 = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic wait_en(input logic [N-1:0] target, input int max_ticks);
      int n;
      n = 0;
      while (seg_en !== target && n < max_ticks) begin
         tick(); n++;
      end
      check("reach seg_en", 32'(seg_en), 32'(target));
   endtask

   task automatic wait_change(input string name, input int max_ticks, output int n);
      logic [N-1:0] prev;
      prev = seg_en;
      n = 0;
      do begin
         tick(); n++;
      end while (seg_en === prev && n < max_ticks);
      if (seg_en === prev) begin
         checks++; errors++;
         $display("FAIL %s: seg_en stayed %b for %0d cycles", name, seg_en, n);
      end
   endtask

   logic [N-1:0] dn_seq [4];
   int n;
   int stop_div;
   int sel;

   initial begin
      dn_seq[0] = 4'b0111; dn_seq[1] = 4'b0011; dn_seq[2] = 4'b0001; dn_seq[3] = 4'b0000;

      // Reset state
      apply_reset();
      chk_en = 1'b1;
      check("reset seg_en", 32'(seg_en), 0);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset error", 32'(error), 0);

      // Power-up with delay 3; later delay changes must not matter
      delay = 8'd3; start = 1'b1; tick(); start = 1'b0; delay = 8'd7;
      wait_change("up0", 50, n);
      check("up0 cycles", 32'(n), 4);  check("up0 seg_en", 32'(seg_en), 32'h1);
      wait_change("up1", 50, n);
      check("up1 cycles", 32'(n), 6);  check("up1 seg_en", 32'(seg_en), 32'h3);
      wait_change("up2", 50, n);
      check("up2 cycles", 32'(n), 6);  check("up2 seg_en", 32'(seg_en), 32'h7);
      wait_change("up3", 50, n);
      check("up3 cycles", 32'(n), 6);  check("up3 seg_en", 32'(seg_en), 32'hf);
      tick(); check("done early", 32'(done), 0);
      tick(); check("done on", 32'(done), 1); check("busy on", 32'(busy), 0);

      // Power-down with delay 0: one bit per cycle
      apply_reset();
      delay = 8'd0; start = 1'b1; tick(); start = 1'b0;
      wait_en(4'b1111, 60);
      tick(); tick();
      check("on before stop", 32'(done), 1);
      stop = 1'b1; tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("dn step", 32'(seg_en), 32'(dn_seq[k]));
      end
      check("dn busy", 32'(busy), 0);
      check("dn done", 32'(done), 0);
      stop = 1'b0;

      // Acknowledge timeout on segment 2
      apply_reset();
      delay = 8'd1; hold_low = 4'b0100; start = 1'b1; tick(); start = 1'b0;
      wait_en(4'b0111, 60);
      repeat (TMO_CYC - 1) tick();
      check("tmo not yet", 32'(error), 0);
      tick();
      check("tmo error", 32'(error), 1);
      check("tmo seg_en", 32'(seg_en), 0);
      start = 1'b1;
      repeat (5) tick();
      check("err ignores start", 32'(seg_en), 0);
      check("err busy", 32'(busy), 0);
      start = 1'b0; stop = 1'b1; tick();
      check("err sticky", 32'(error), 1);
      stop = 1'b0; hold_low = '0;

      // Abort during the delay before segment 2
      apply_reset();
      delay = 8'd4; start = 1'b1; tick(); start = 1'b0;
      wait_en(4'b0011, 60);
      tick(); tick();
      stop = 1'b1;
      wait_change("abort1", 50, n);
      check("abort1 cycles", 32'(n), 6); check("abort1 seg_en", 32'(seg_en), 32'h1);
      wait_change("abort0", 50, n);
      check("abort0 cycles", 32'(n), 5); check("abort0 seg_en", 32'(seg_en), 32'h0);
      check("abort busy", 32'(busy), 0);
      stop = 1'b0;

      // Reset while waiting for segment 3 acknowledge
      apply_reset();
      delay = 8'd2; start = 1'b1; tick(); start = 1'b0;
      wait_en(4'b1111, 60);
      check("pre-reset busy", 32'(busy), 1);
      reset = 1'b1; tick(); reset = 1'b0; h1 = '0; h2 = '0;
      check("midreset seg_en", 32'(seg_en), 0);
      check("midreset busy", 32'(busy), 0);
      check("midreset done", 32'(done), 0);
      check("midreset error", 32'(error), 0);

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("both seg_en", 32'(seg_en), 0);
         check("both busy", 32'(busy), 0);
      end
      start = 1'b0; stop = 1'b0;

      // Randomized traffic
      stop_div = 15;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            sel      = $urandom_range(0, 2);
            ack_rand = (sel == 1);
            hold_low = (sel == 2) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            case ($urandom_range(0, 2))
               0: stop_div = 3;
               1: stop_div = 15;
               default: stop_div = 63;
            endcase
         end
         reset = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, stop_div) == 0);
         delay = DW'($urandom_range(0, 4));
         tick();
      end
      reset = 1'b0; start = 1'b0; stop = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
